xadac_exe_arb: RTL
==================

XADAC_EXE_ARB -- requirements
Module: xadac_exe_arb

Interface
REQ-001 SHALL have parameter IdWidth, default 3, width of the instruction id.
REQ-002 SHALL have parameter InstrWidth, default 32, width of the instruction word.
REQ-003 SHALL have parameter DataWidth, default 128, width of the operand and result data.
REQ-004 SHALL have parameter MaxOut, default 4, maximum outstanding requests per unit; CntWidth = clog2(MaxOut+1).
REQ-005 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-007 SHALL have ports slv_req_valid in 1, slv_req_ready out 1, slv_req_id in IdWidth, slv_req_instr in InstrWidth, slv_req_data in DataWidth: the upstream execute request.
REQ-008 SHALL have ports slv_rsp_valid out 1, slv_rsp_ready in 1, slv_rsp_id out IdWidth, slv_rsp_data out DataWidth: the upstream execute response.
REQ-009 SHALL have, for k in {0,1}, ports uk_req_valid out 1, uk_req_ready in 1, uk_req_id out IdWidth, uk_req_instr out InstrWidth, uk_req_data out DataWidth: the request to unit k (0 = vector ALU, 1 = vector LSU).
REQ-010 SHALL have, for k in {0,1}, ports uk_rsp_valid in 1, uk_rsp_ready out 1, uk_rsp_id in IdWidth, uk_rsp_data in DataWidth: the response from unit k.
REQ-011 SHALL have ports err out 1 (sticky protocol error) and uk_cnt out CntWidth (outstanding count of unit k).

Function
REQ-012 SHALL route a request to unit 1 when slv_req_instr[6:0] is 7'h07 or 7'h27, otherwise to unit 0.
REQ-013 SHALL drive id/instr/data unchanged to both units and assert uk_req_valid only for the selected unit k, only when slv_req_valid=1 and uk_cnt<MaxOut.
REQ-014 SHALL drive slv_req_ready = uk_req_ready of the selected unit AND uk_cnt<MaxOut, combinationally; request path latency is 0 cycles.
REQ-015 SHALL never depend uk_req_valid on uk_req_ready (no valid-after-ready loop).
REQ-016 SHALL increment uk_cnt on a uk_req handshake and decrement it on a uk_rsp handshake; both in one cycle leave it unchanged.
REQ-017 SHALL hold the response in a single output register (valid, id, data); slv_rsp_* driven only from this register.
REQ-018 SHALL consider the output register free when empty or when slv_rsp_valid and slv_rsp_ready are both 1 in the same cycle.
REQ-019 SHALL grant at most one unit per cycle: if only one uk_rsp_valid, grant it; if both, grant the unit not granted last (round-robin pointer).
REQ-020 SHALL drive uk_rsp_ready = granted(k) AND register free; on handshake load id/data next cycle, set valid, update last-grant pointer to k.
REQ-021 SHALL clear slv_rsp_valid after a slv_rsp handshake with no new load that cycle; response latency unit-to-upstream is exactly 1 cycle when free.
REQ-022 SHALL hold slv_rsp_valid/id/data stable while slv_rsp_valid=1 and slv_rsp_ready=0.
REQ-023 SHALL, on a uk_rsp handshake with uk_cnt=0, set err=1, keep uk_cnt at 0 (no wrap), and still forward the response.
REQ-024 SHALL never increment uk_cnt beyond MaxOut (guaranteed by REQ-013).

Reset
REQ-025 SHALL, when rst=1 at a clock edge, clear slv_rsp_valid, slv_rsp_id, slv_rsp_data, u0_cnt, u1_cnt, err, and set last-grant pointer to unit 1 (so unit 0 wins first tie).
REQ-026 SHALL, while rst=1, drive slv_req_ready=0, u0_req_valid=0, u1_req_valid=0, u0_rsp_ready=0, u1_rsp_ready=0.
REQ-027 SHALL discard any in-flight response and outstanding counts on reset mid-operation; no response is emitted for pre-reset requests.

Verification
REQ-028 SHALL cover: instr[6:0]=7'h07, id=5, u1_req_ready=1 -> u1_req_valid=1, u0_req_valid=0, slv_req_ready=1, u1_cnt 0->1.
REQ-029 SHALL cover: 4 unit-0 requests with no responses -> u0_cnt=4, 5th request sees slv_req_ready=0 and u0_req_valid=0; unit-1 request still accepted same cycle.
REQ-030 SHALL cover: after reset, u0 and u1 rsp valid together (ids 2, 3), slv_rsp_ready=1 -> id 2 out cycle+1, id 3 cycle+2; next tie grants unit 0 again only after unit 1 won.
REQ-031 SHALL cover: slv_rsp_ready=0 for 3 cycles with response id 6 held -> id/data stable, uk_rsp_ready=0 for both units, no loss.
REQ-032 SHALL cover: u1_rsp handshake with u1_cnt=0 -> err=1 sticky, u1_cnt stays 0, response forwarded; cleared only by rst.
REQ-033 SHALL cover: rst=1 while slv_rsp_valid=1 and u0_cnt=2 -> next cycle slv_rsp_valid=0, u0_cnt=0, err=0.

Source files
------------

// File: rtl/xadac_exe_arb.sv
// rtl/xadac_exe_arb.sv - execute-request router and response arbiter for vector ALU/LSU
//
// Purpose:
//   Routes each upstream execute request to either the vector ALU (unit 0) or
//   the vector LSU (unit 1) based on the instruction opcode. The request path
//   is purely combinational. Each unit's outstanding requests are counted and
//   capped at MaxOut. Responses from the two units are arbitrated round-robin
//   into a single output register that drives the upstream response.
//
// Ports:
//   clk, rst                     clock; synchronous active-high reset
//   slv_req_*                    upstream request (valid/ready/id/instr/data)
//   slv_rsp_*                    upstream response (valid/ready/id/data), registered
//   u0_req_*, u1_req_*           requests to unit 0 (ALU) and unit 1 (LSU)
//   u0_rsp_*, u1_rsp_*           responses from unit 0 and unit 1
//   err                          sticky: a unit responded with nothing outstanding
//   u0_cnt, u1_cnt               outstanding request count per unit

module xadac_exe_arb #(
    parameter int IdWidth    = 3,
    parameter int InstrWidth = 32,
    parameter int DataWidth  = 128,
    parameter int MaxOut     = 4,
    localparam int CntWidth  = $clog2(MaxOut + 1)
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  slv_req_valid,
    output logic                  slv_req_ready,
    input  logic [IdWidth-1:0]    slv_req_id,
    input  logic [InstrWidth-1:0] slv_req_instr,
    input  logic [DataWidth-1:0]  slv_req_data,

    output logic                  slv_rsp_valid,
    input  logic                  slv_rsp_ready,
    output logic [IdWidth-1:0]    slv_rsp_id,
    output logic [DataWidth-1:0]  slv_rsp_data,

    output logic                  u0_req_valid,
    input  logic                  u0_req_ready,
    output logic [IdWidth-1:0]    u0_req_id,
    output logic [InstrWidth-1:0] u0_req_instr,
    output logic [DataWidth-1:0]  u0_req_data,

    output logic                  u1_req_valid,
    input  logic                  u1_req_ready,
    output logic [IdWidth-1:0]    u1_req_id,
    output logic [InstrWidth-1:0] u1_req_instr,
    output logic [DataWidth-1:0]  u1_req_data,

    input  logic                  u0_rsp_valid,
    output logic                  u0_rsp_ready,
    input  logic [IdWidth-1:0]    u0_rsp_id,
    input  logic [DataWidth-1:0]  u0_rsp_data,

    input  logic                  u1_rsp_valid,
    output logic                  u1_rsp_ready,
    input  logic [IdWidth-1:0]    u1_rsp_id,
    input  logic [DataWidth-1:0]  u1_rsp_data,

    output logic                  err,
    output logic [CntWidth-1:0]   u0_cnt,
    output logic [CntWidth-1:0]   u1_cnt
);

    localparam logic [CntWidth-1:0] CntMax = CntWidth'(MaxOut);
    localparam logic [CntWidth-1:0] CntOne = CntWidth'(1);

    logic sel_lsu;
    logic u0_room, u1_room;
    logic u0_inc, u1_inc, u0_dec, u1_dec;
    logic rsp_free;
    logic gnt0, gnt1;
    logic last_gnt;     // 1 = unit 1 was granted most recently

    // Load/store major opcodes (LOAD-FP 0x07, STORE-FP 0x27) go to the LSU.
    assign sel_lsu = (slv_req_instr[6:0] == 7'h07) || (slv_req_instr[6:0] == 7'h27);

    assign u0_room = (u0_cnt < CntMax);
    assign u1_room = (u1_cnt < CntMax);

    assign u0_req_id    = slv_req_id;
    assign u0_req_instr = slv_req_instr;
    assign u0_req_data  = slv_req_data;
    assign u1_req_id    = slv_req_id;
    assign u1_req_instr = slv_req_instr;
    assign u1_req_data  = slv_req_data;

    // Valid is formed without looking at the unit's ready.
    assign u0_req_valid  = !rst && slv_req_valid && !sel_lsu && u0_room;
    assign u1_req_valid  = !rst && slv_req_valid &&  sel_lsu && u1_room;
    assign slv_req_ready = !rst && (sel_lsu ? (u1_req_ready && u1_room)
                                            : (u0_req_ready && u0_room));

    // Output register can accept a new response when empty or draining now.
    assign rsp_free = !slv_rsp_valid || slv_rsp_ready;

    // On a tie the unit not granted last time wins.
    assign gnt0 = u0_rsp_valid && (!u1_rsp_valid ||  last_gnt);
    assign gnt1 = u1_rsp_valid && (!u0_rsp_valid || !last_gnt);

    assign u0_rsp_ready = !rst && gnt0 && rsp_free;
    assign u1_rsp_ready = !rst && gnt1 && rsp_free;

    assign u0_inc = u0_req_valid && u0_req_ready;
    assign u1_inc = u1_req_valid && u1_req_ready;
    assign u0_dec = u0_rsp_valid && u0_rsp_ready;
    assign u1_dec = u1_rsp_valid && u1_rsp_ready;

    // A response with nothing outstanding saturates at zero instead of wrapping.
    function automatic logic [CntWidth-1:0] cnt_next(input logic [CntWidth-1:0] cnt,
                                                     input logic inc, input logic dec);
        if (inc && !dec)
            return cnt + CntOne;
        else if (dec && !inc && cnt != '0)
            return cnt - CntOne;
        else
            return cnt;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            slv_rsp_valid <= 1'b0;
            slv_rsp_id    <= '0;
            slv_rsp_data  <= '0;
            u0_cnt        <= '0;
            u1_cnt        <= '0;
            err           <= 1'b0;
            last_gnt      <= 1'b1;
        end else begin
            u0_cnt <= cnt_next(u0_cnt, u0_inc, u0_dec);
            u1_cnt <= cnt_next(u1_cnt, u1_inc, u1_dec);
            if ((u0_dec && u0_cnt == '0) || (u1_dec && u1_cnt == '0))
                err <= 1'b1;

            if (u0_dec) begin
                slv_rsp_valid <= 1'b1;
                slv_rsp_id    <= u0_rsp_id;
                slv_rsp_data  <= u0_rsp_data;
                last_gnt      <= 1'b0;
            end else if (u1_dec) begin
                slv_rsp_valid <= 1'b1;
                slv_rsp_id    <= u1_rsp_id;
                slv_rsp_data  <= u1_rsp_data;
                last_gnt      <= 1'b1;
            end else if (slv_rsp_valid && slv_rsp_ready) begin
                slv_rsp_valid <= 1'b0;
            end
        end
    end

endmodule
